uart_periph: RTL and testbench

//  UART-side responder of the uart_if link (RX modport); the core drives the TX modport.

---
 rtl/uart_periph.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph.sv
// -----------------------------------------------------------------------------
// uart_periph
//   UART-side responder of the core's MMIO link. Decodes core accesses to the
//   CTRL / RX / TX registers, serializes TX bytes as 8N1 onto tx_o, and
//   deserializes rx_i into a one-byte holding register with a valid flag.
//   TX and RX run independently, so tx_o can be looped back to rx_i.
//
// Parameters
//   CLK_FREQ   core clock in Hz
//   BAUD_RATE  line rate in baud (a uart_baud_rate_t value, e.g. 115_200)
//
// Ports
//   clk      in   1  core clock
//   rst_n    in   1  asynchronous active-low reset
//   ctrl_i   in   5  {en, we, load_signed, addr[1:0]}
//   send_i   in   8  write data from the core
//   recv_o   out  8  read data to the core, registered (1-cycle latency)
//   rx_i     in   1  serial input, asynchronous to clk
//   tx_o     out  1  serial output, idle high
//
// Register map (addr)
//   0 CTRL  read {6'b0, rx_valid, tx_ready}
//   1 RX    read rx_data, clears rx_valid
//   2 TX    write starts a frame when tx_ready=1, otherwise dropped
//   3       reads 8'h00
// -----------------------------------------------------------------------------
module uart_periph #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ctrl_i,
  input  logic [7:0] send_i,
  output logic [7:0] recv_o,
  input  logic       rx_i,
  output logic       tx_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Mid-bit sampling and the half-bit start check need a few clocks per bit.
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_periph: CLKS_PER_BIT=%0d must be at least 4", CLKS_PER_BIT);
  end

  typedef enum logic [1:0] {
    ADDR_CTRL = 2'd0,
    ADDR_RX   = 2'd1,
    ADDR_TX   = 2'd2,
    ADDR_NONE = 2'd3
  } uart_addr_t;

  typedef struct packed {
    logic       en;
    logic       we;
    logic       load_signed;
    uart_addr_t addr;
  } uart_ctrl_t;

  typedef struct packed {
    logic rx_valid;
    logic tx_ready;
  } uart_rv_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  uart_ctrl_t ctrl;
  logic       rd_en;
  logic       rd_rx;
  logic       wr_tx;
  logic       tx_ready;
  logic       tx_start;
  logic       unused_load_signed;

  assign ctrl     = uart_ctrl_t'(ctrl_i);
  assign rd_en    = ctrl.en && !ctrl.we;
  assign rd_rx    = rd_en && (ctrl.addr == ADDR_RX);
  assign wr_tx    = ctrl.en && ctrl.we && (ctrl.addr == ADDR_TX);
  assign tx_start = wr_tx && tx_ready;
  // The core performs sign extension itself.
  assign unused_load_signed = ctrl.load_signed;

  // ---------------------------------------------------------------------------
  // TX: state register / next-state / output
  // ---------------------------------------------------------------------------
  frame_state_t     tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_q, tx_d;
  logic             tx_bit_end;

  // NOTE: flops use non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign tx_ready   = (tx_state_q == ST_IDLE);

  // NOTE: each combinational output is defaulted first, so no path infers a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_cnt_d   = (tx_state_q == ST_IDLE || tx_bit_end) ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (tx_start) begin
          tx_state_d = ST_START;
          tx_byte_d  = send_i;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_state_d = ST_DATA;
          tx_idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_idx_d   = tx_idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) tx_state_d = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the pin comes straight off a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_byte_d[tx_idx_d];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_o = tx_q;

  // ---------------------------------------------------------------------------
  // RX: synchronizer, then state register / next-state / output
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  // Two flops resolve metastability on the asynchronous line; idle level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  frame_state_t     rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_bit_end;
  logic             rx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s_q) rx_state_d = ST_START;
      end
      ST_START: begin
        // Half a bit in: still low means a real start bit, else a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_idx_d   = rx_idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A byte is delivered only when the stop bit samples high; framing errors vanish.
  always_comb begin
    rx_done = (rx_state_q == ST_STOP) && rx_bit_end && rx_s_q;
  end

  // ---------------------------------------------------------------------------
  // Holding register and read data
  // ---------------------------------------------------------------------------
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic [7:0]    recv_q, recv_d;
  uart_rv_ctrl_t rv;

  assign rv = '{rx_valid: rx_valid_q, tx_ready: tx_ready};

  // Completion beats a coincident RX read: the read returns the old byte and
  // the flag stays set for the new one. Overrun simply overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (rx_done) begin
      rx_data_q  <= rx_shift_q;
      rx_valid_q <= 1'b1;
    end else if (rd_rx) begin
      rx_valid_q <= 1'b0;
    end
  end

  always_comb begin
    recv_d = recv_q;
    if (rd_en) begin
      unique case (ctrl.addr)
        ADDR_CTRL: recv_d = {6'b0, rv};
        ADDR_RX:   recv_d = rx_data_q;
        default:   recv_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) recv_q <= '0;
    else        recv_q <= recv_d;
  end

  assign recv_o = recv_q;

endmodule

// File: tb/tb_uart_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_periph
//   Self-checking bench for uart_periph at 10 clocks per bit. Stimulus tasks
//   push expected read data and expected TX bytes into queues from a small
//   behavioural model; independent monitors pop and compare when the DUT
//   answers a read or puts a frame on tx_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_periph;

  localparam int unsigned CLK_FREQ = 1_152_000;
  localparam int unsigned BAUD     = 115_200;
  localparam int          CPB      = 10;
  localparam int          FRAME    = 10 * CPB;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_RX   = 2'd1;
  localparam logic [1:0] A_TX   = 2'd2;
  localparam logic [1:0] A_NONE = 2'd3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [4:0] ctrl_i = '0;
  logic [7:0] send_i = '0;
  logic [7:0] recv_o;
  logic       rx_i   = 1'b1;
  logic       tx_o;

  uart_periph #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl_i(ctrl_i),
    .send_i(send_i),
    .recv_o(recv_o),
    .rx_i  (rx_i),
    .tx_o  (tx_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: TX is busy for one frame time after an accepted write;
  // the RX holding register is a byte plus a flag.
  int         tx_free_at = 0;
  bit         m_rx_valid = 1'b0;
  logic [7:0] m_rx_data  = 8'h00;
  bit         saw_rst    = 1'b0;

  logic [7:0] tx_exp_q[$];

  typedef struct {
    string      name;
    logic [7:0] val;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  always @(negedge rst_n) saw_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A read issued now is sampled at edge cyc+1.
  function automatic logic [7:0] ctrl_expect();
    logic rdy;
    rdy = (cyc + 1 > tx_free_at);
    return {6'b0, m_rx_valid, rdy};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    ctrl_i = {1'b1, 1'b0, 1'($urandom_range(0, 1)), a};
    rd_q.push_back('{nm, exp});
    wait_cycles(1);
    ctrl_i = '0;
  endtask

  task automatic cpu_read_rx(input string nm);
    cpu_read(A_RX, m_rx_data, nm);
    m_rx_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    ctrl_i = {1'b1, 1'b1, 1'b0, a};
    send_i = d;
    if (a == A_TX && (cyc + 1 > tx_free_at)) begin
      tx_exp_q.push_back(d);
      tx_free_at = cyc + 1 + FRAME;
    end
    wait_cycles(1);
    ctrl_i = '0;
    send_i = 8'($urandom);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cycles(CPB);
    end
    rx_i = stop_bit;
    wait_cycles(CPB);
    rx_i = 1'b1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_frame(b, 1'b1);
    m_rx_data  = b;
    m_rx_valid = 1'b1;
  endtask

  // Read monitor: recv_o is valid the cycle after a sampled read.
  initial begin : rd_monitor
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && ctrl_i[4] === 1'b1 && ctrl_i[3] === 1'b0) begin
        @(negedge clk);
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: read data 0x%0h with no expectation queued", recv_o);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check(e.name, recv_o, e.val);
        end
      end
    end
  end

  // TX monitor: a low tx_o starts a frame; every cycle of all ten bits is
  // compared against the ideal 8N1 waveform of the expected byte.
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_o === 1'b0) begin
        logic [7:0] exp_b;
        logic [9:0] mid;
        bit         have;
        int         bad;
        saw_rst = 1'b0;
        have    = (tx_exp_q.size() != 0);
        exp_b   = have ? tx_exp_q.pop_front() : 8'h00;
        bad     = 0;
        mid     = '0;
        for (int i = 0; i < FRAME; i++) begin
          logic lvl;
          if (i != 0) @(negedge clk);
          if (i < CPB)           lvl = 1'b0;
          else if (i >= 9 * CPB) lvl = 1'b1;
          else                   lvl = exp_b[i / CPB - 1];
          if (tx_o !== lvl) bad++;
          if (i % CPB == CPB / 2) mid[i / CPB] = tx_o;
        end
        if (!saw_rst) begin
          check("tx_frame_expected", have, 1);
          check("tx_frame_data", mid[8:1], exp_b);
          check("tx_frame_timing", bad, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] b;
    rst_n  = 1'b0;
    rx_i   = 1'b1;
    ctrl_i = '0;
    send_i = '0;
    #23;
    check("reset_tx", tx_o, 1);
    check("reset_recv", recv_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Register map after reset; writes to non-TX addresses do nothing.
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_reset");
    cpu_read(A_NONE, 8'h00, "addr3_read");
    cpu_write(A_CTRL, 8'hFF);
    cpu_write(A_RX, 8'hFF);
    cpu_write(A_NONE, 8'hFF);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_ignored_writes");
    wait_cycles(5);

    // 0xA5 frame, mid-frame status, write dropped on the last stop cycle.
    cpu_write(A_TX, 8'hA5);
    wait_cycles(39);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_mid_frame");
    wait_cycles(59);
    cpu_write(A_TX, 8'h5A);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_frame");
    wait_cycles(FRAME + 20);

    // Write while busy is dropped; the frame in flight is unchanged.
    b = 8'($urandom);
    cpu_write(A_TX, b);
    wait_cycles(30);
    cpu_write(A_TX, ~b);
    wait_cycles(FRAME);

    // Back-to-back frames: next write lands on the first ready cycle.
    cpu_write(A_TX, 8'($urandom));
    wait_cycles(FRAME);
    cpu_write(A_TX, 8'($urandom));
    wait_cycles(FRAME + 10);

    // Receive 0x3C.
    rx_byte(8'h3C);
    wait_cycles(2);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_rx_valid");
    cpu_read_rx("rx_data_3c");
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_rx_cleared");

    // Short low glitch is rejected.
    rx_i = 1'b0;
    wait_cycles(3);
    rx_i = 1'b1;
    wait_cycles(20);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_glitch");

    // Framing error with nothing held.
    rx_frame(8'h5A, 1'b0);
    wait_cycles(20);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_framing_err");

    // Overrun: the second byte overwrites the first.
    rx_byte(8'h11);
    rx_byte(8'h22);
    wait_cycles(2);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_overrun");

    // Framing error while a byte is held leaves it untouched.
    rx_frame(8'h99, 1'b0);
    wait_cycles(20);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_framing_err_held");

    // RX read on the completion edge of the next frame (stop sampled at edge 98).
    fork
      rx_frame(8'h33, 1'b1);
      begin
        wait_cycles(97);
        cpu_read(A_RX, 8'h22, "rx_read_coincident");
      end
    join
    m_rx_data  = 8'h33;
    m_rx_valid = 1'b1;
    wait_cycles(2);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_coincident");
    cpu_read_rx("rx_after_coincident");
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_coincident_read");

    // Random traffic with TX and RX running at the same time.
    for (int k = 0; k < 6; k++) begin
      logic [7:0] tb_byte;
      logic [7:0] rb_byte;
      tb_byte = 8'($urandom);
      rb_byte = 8'($urandom);
      fork
        cpu_write(A_TX, tb_byte);
        rx_byte(rb_byte);
      join
      wait_cycles(1 + $urandom_range(0, 5));
      cpu_read(A_CTRL, ctrl_expect(), "ctrl_random");
      cpu_read_rx("rx_random");
      if ($urandom_range(0, 1) == 1) cpu_write(A_TX, 8'($urandom));
      wait_cycles(FRAME + 5);
    end

    // Reset in the middle of a TX frame with a byte held.
    rx_byte(8'hC3);
    cpu_write(A_TX, 8'h96);
    wait_cycles(35);
    rst_n = 1'b0;
    #1;
    check("tx_async_reset", tx_o, 1);
    tx_exp_q.delete();
    tx_free_at = 0;
    m_rx_valid = 1'b0;
    m_rx_data  = 8'h00;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);
    cpu_read(A_CTRL, ctrl_expect(), "ctrl_after_midframe_reset");
    wait_cycles(FRAME + 10);

    check("rd_queue_drained", rd_q.size(), 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
